// File: rtl/maxpool_sched_pkg.sv
// maxpool_sched_pkg: shared widths, rail levels and FSM encoding for the max-pool scheduler.
package maxpool_sched_pkg;
  localparam int BIT_DATA = 8;
  localparam logic ON = 1'b1;
  localparam logic OFF = 1'b0;
  localparam logic [BIT_DATA-1:0] SPACER = '0;
  typedef enum logic [2:0] {COLLECT, ISSUE, WAIT_DATA, ACK_HI, WAIT_RTZ, OUTPUT} state_e;
endpackage

// File: rtl/maxpool_sched_rail_sync.sv
// rail_sync: flop chain that brings one asynchronous kernel signal into the clk domain.
module rail_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else r_sync <= (r_sync << 1) | STAGES'(i_d);
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/maxpool_sched.sv
// maxpool_sched: buffers a pixel stream into 2x2 windows, runs the dual-rail four-phase
// handshake with the max kernel and returns each pooled value on a valid/ready stream.
module maxpool_sched
  import maxpool_sched_pkg::*;
#(
  parameter int DATA_W      = BIT_DATA,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] k_x0_t,
  output logic [DATA_W-1:0] k_x0_f,
  output logic [DATA_W-1:0] k_x1_t,
  output logic [DATA_W-1:0] k_x1_f,
  output logic [DATA_W-1:0] k_x2_t,
  output logic [DATA_W-1:0] k_x2_f,
  output logic [DATA_W-1:0] k_x3_t,
  output logic [DATA_W-1:0] k_x3_f,
  input  logic              k_ack_prev,
  input  logic [DATA_W-1:0] k_y_t,
  input  logic [DATA_W-1:0] k_y_f,
  output logic              k_ack_nxt,
  output logic              frame_done,
  output logic              err
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                   r_state, w_next;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic [DATA_W-1:0]        r_lb [IMG_W];
  logic [DATA_W-1:0]        r_lo, r_out;
  logic [3:0][DATA_W-1:0]   r_x;
  logic                     r_last, r_in_ready, r_err;
  logic [TW-1:0]            r_tmo;
  logic                     w_ack, w_yv, w_ys, w_acc, w_win, w_col_end, w_row_end, w_stay, w_drive;

  rail_sync #(.STAGES(SYNC_STAGES)) u_ack (.clk, .rst_n(reset_n), .i_d(k_ack_prev), .o_q(w_ack));
  rail_sync #(.STAGES(SYNC_STAGES)) u_yv (.clk, .rst_n(reset_n), .i_d(&(k_y_t ^ k_y_f)), .o_q(w_yv));
  rail_sync #(.STAGES(SYNC_STAGES)) u_ys (.clk, .rst_n(reset_n), .i_d(~|(k_y_t | k_y_f)), .o_q(w_ys));

  assign w_acc     = in_valid & r_in_ready;
  assign w_win     = w_acc & r_row[0] & r_col[0];
  assign w_col_end = r_col == CW'(IMG_W - 1);
  assign w_row_end = r_row == RW'(IMG_H - 1);
  assign w_stay    = (r_state == WAIT_DATA || r_state == WAIT_RTZ) && w_next == r_state;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= COLLECT;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      COLLECT:   w_next = w_win ? ISSUE : COLLECT;
      ISSUE:     w_next = WAIT_DATA;
      WAIT_DATA: w_next = (w_ack && w_yv) ? ACK_HI : WAIT_DATA;
      ACK_HI:    w_next = WAIT_RTZ;
      WAIT_RTZ:  w_next = (!w_ack && w_ys) ? OUTPUT : WAIT_RTZ;
      OUTPUT:    w_next = out_ready ? COLLECT : OUTPUT;
      default:   w_next = COLLECT;
    endcase
  end

  // Operands are only on the rails between issue and the kernel's completion.
  always_comb begin
    w_drive    = r_state == ISSUE || r_state == WAIT_DATA;
    k_x0_t     = w_drive ? r_x[0] : DATA_W'(SPACER);
    k_x0_f     = w_drive ? ~r_x[0] : DATA_W'(SPACER);
    k_x1_t     = w_drive ? r_x[1] : DATA_W'(SPACER);
    k_x1_f     = w_drive ? ~r_x[1] : DATA_W'(SPACER);
    k_x2_t     = w_drive ? r_x[2] : DATA_W'(SPACER);
    k_x2_f     = w_drive ? ~r_x[2] : DATA_W'(SPACER);
    k_x3_t     = w_drive ? r_x[3] : DATA_W'(SPACER);
    k_x3_f     = w_drive ? ~r_x[3] : DATA_W'(SPACER);
    k_ack_nxt  = (r_state == ACK_HI || r_state == WAIT_RTZ) ? ON : OFF;
    out_valid  = r_state == OUTPUT;
    frame_done = (r_state == OUTPUT) & out_ready & r_last;
  end

  assign in_ready = r_in_ready;
  assign out_data = r_out;
  assign err      = r_err;

  always_ff @(posedge clk)
    if (w_acc && !r_row[0]) r_lb[r_col] <= in_data;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_lo       <= '0;
      r_x        <= '0;
      r_last     <= 1'b0;
      r_out      <= '0;
      r_in_ready <= 1'b0;
      r_tmo      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_in_ready <= w_next == COLLECT;
      if (w_acc && r_row[0] && !r_col[0]) r_lo <= in_data;
      if (w_win) begin
        r_x    <= {in_data, r_lo, r_lb[r_col], r_lb[r_col ^ CW'(1)]};
        r_last <= w_row_end & w_col_end;
      end
      if (w_acc) begin
        r_col <= w_col_end ? '0 : r_col + CW'(1);
        if (w_col_end) r_row <= w_row_end ? '0 : r_row + RW'(1);
      end
      if (r_state == WAIT_DATA && w_next == ACK_HI) r_out <= k_y_t;
      r_tmo <= w_stay ? (r_tmo == TW'(TIMEOUT) ? r_tmo : r_tmo + TW'(1)) : '0;
      r_err <= r_err | (w_stay && r_tmo == TW'(TIMEOUT - 1));
    end
endmodule

// File: tb/tb_maxpool_sched.sv
// tb_maxpool_sched: drives frames through maxpool_sched against a behavioural dual-rail max
// kernel and a window-max reference queue; covers reset, backpressure and timeout.
module tb_maxpool_sched;
  logic clk, reset_n, in_valid, in_ready, out_valid, out_ready, k_ack_prev, k_ack_nxt, frame_done, err;
  logic [7:0] in_data, out_data, k_y_t, k_y_f;
  logic [7:0] k_x0_t, k_x0_f, k_x1_t, k_x1_f, k_x2_t, k_x2_f, k_x3_t, k_x3_f;

  maxpool_sched #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .k_x0_t(k_x0_t), .k_x0_f(k_x0_f), .k_x1_t(k_x1_t), .k_x1_f(k_x1_f),
    .k_x2_t(k_x2_t), .k_x2_f(k_x2_f), .k_x3_t(k_x3_t), .k_x3_f(k_x3_f),
    .k_ack_prev(k_ack_prev), .k_y_t(k_y_t), .k_y_f(k_y_f), .k_ack_nxt(k_ack_nxt),
    .frame_done(frame_done), .err(err));

  typedef struct { logic signed [7:0] a, b, c, d, exp; } vec_t;
  typedef struct { logic signed [7:0] v; bit last; } exp_t;

  int errors = 0, checks = 0, fd_cnt = 0, out_idx = 0;
  bit hang = 0, bp = 0;
  logic signed [7:0] frame [64];
  logic signed [7:0] got [16];
  exp_t q [$];
  vec_t tbl [6];
  wire [7:0] xt [4];
  wire [7:0] xf [4];
  assign xt[0] = k_x0_t; assign xt[1] = k_x1_t; assign xt[2] = k_x2_t; assign xt[3] = k_x3_t;
  assign xf[0] = k_x0_f; assign xf[1] = k_x1_f; assign xf[2] = k_x2_f; assign xf[3] = k_x3_f;
  wire all_valid  = &(xt[0] ^ xf[0]) && &(xt[1] ^ xf[1]) && &(xt[2] ^ xf[2]) && &(xt[3] ^ xf[3]);
  wire all_spacer = ((xt[0] | xf[0] | xt[1] | xf[1] | xt[2] | xf[2] | xt[3] | xf[3]) == 8'd0);
  wire rails_zero = all_spacer;

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic signed [7:0] max4(input logic signed [7:0] a, b, c, d);
    logic signed [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Behavioural kernel: random settle delay, holds its result until the scheduler acknowledges.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      k_ack_prev <= 0; k_y_t <= 0; k_y_f <= 0;
    end else if (!hang && $urandom_range(0, 2) != 0) begin
      if (all_valid && !k_ack_nxt) begin
        k_ack_prev <= 1;
        k_y_t <= max4(xt[0], xt[1], xt[2], xt[3]);
        k_y_f <= ~max4(xt[0], xt[1], xt[2], xt[3]);
      end else if (all_spacer) begin
        k_ack_prev <= 0;
        if (k_ack_nxt) begin k_y_t <= 0; k_y_f <= 0; end
      end
    end

  initial out_ready = 0;
  always @(posedge clk) begin
    #2;
    out_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk)
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk(0, "unexpected_output", $signed(out_data), 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk(out_data == e.v, "out_data", $signed(out_data), e.v);
          chk(frame_done == e.last, "frame_done_align", frame_done, e.last);
          if (out_idx < 16) got[out_idx] = out_data;
          out_idx++;
        end
      end
      if (frame_done) fd_cnt++;
      for (int i = 0; i < 4; i++)
        if ((xt[i] | xf[i]) != 0) chk((xt[i] ^ xf[i]) == 8'hFF, "rail_complement", xt[i], ~xf[i] & 8'hFF);
    end

  task automatic push(input int idx);
    int t = 0;
    in_valid = 1;
    in_data = frame[idx];
    while (!in_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk(0, "in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push(i);
  endtask

  task automatic build_model();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        exp_t e;
        e.v = max4(frame[16*r+2*c], frame[16*r+2*c+1], frame[16*r+8+2*c], frame[16*r+8+2*c+1]);
        e.last = (r == 3 && c == 3);
        q.push_back(e);
      end
    out_idx = 0;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    chk(q.size() == 0, "drain", q.size(), 0);
  endtask

  initial begin
    logic [7:0] held;
    int t;
    tbl[0] = '{a: 3,    b: -5,   c: 7,    d: 1,    exp: 7};
    tbl[1] = '{a: -128, b: -1,   c: -2,   d: -127, exp: -1};
    tbl[2] = '{a: 0,    b: 0,    c: 0,    d: 0,    exp: 0};
    tbl[3] = '{a: 127,  b: -128, c: 126,  d: 0,    exp: 127};
    tbl[4] = '{a: -128, b: -128, c: -128, d: -128, exp: -128};
    tbl[5] = '{a: 5,    b: 5,    c: -6,   d: 4,    exp: 5};
    reset_n = 0; in_valid = 0; in_data = 0;
    #12;
    chk(rails_zero, "rst_rails", 0, 1);
    chk(k_ack_nxt == 0, "rst_ack_nxt", k_ack_nxt, 0);
    chk(in_ready == 0, "rst_in_ready", in_ready, 0);
    chk(out_valid == 0, "rst_out_valid", out_valid, 0);
    chk(out_data == 0, "rst_out_data", out_data, 0);
    chk(frame_done == 0, "rst_frame_done", frame_done, 0);
    chk(err == 0, "rst_err", err, 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk(in_ready == 1, "in_ready_after_reset", in_ready, 1);

    rand_frame();
    for (int k = 0; k < 6; k++) begin
      int b;
      b = 16 * (k / 4) + 2 * (k % 4);
      frame[b] = tbl[k].a; frame[b+1] = tbl[k].b; frame[b+8] = tbl[k].c; frame[b+9] = tbl[k].d;
    end
    build_model();
    push_range(0, 9);
    chk(k_x0_t == 8'd3, "issue_x0_t", k_x0_t, 3);
    chk(k_x0_f == 8'hFC, "issue_x0_f", k_x0_f, 8'hFC);
    chk(k_x1_t == 8'hFB, "issue_x1_t", k_x1_t, 8'hFB);
    chk(k_x2_t == 8'd7, "issue_x2_t", k_x2_t, 7);
    chk(k_x3_t == 8'd1, "issue_x3_t", k_x3_t, 1);
    chk(k_x3_f == 8'hFE, "issue_x3_f", k_x3_f, 8'hFE);
    chk(in_ready == 0, "issue_in_ready", in_ready, 0);
    push_range(10, 63);
    drain();
    for (int k = 0; k < 6; k++) chk(got[k] == tbl[k].exp, "table_window", got[k], tbl[k].exp);
    chk(fd_cnt == 1, "frame_done_count1", fd_cnt, 1);

    for (int i = 0; i < 64; i++) frame[i] = 8'(i);
    build_model();
    push_range(0, 63);
    drain();
    chk(got[0] == 9, "ramp_out0", got[0], 9);
    chk(got[3] == 15, "ramp_out3", got[3], 15);
    chk(got[4] == 25, "ramp_out4", got[4], 25);
    chk(got[15] == 63, "ramp_out15", got[15], 63);
    chk(fd_cnt == 2, "frame_done_count2", fd_cnt, 2);

    rand_frame();
    build_model();
    bp = 1;
    push_range(0, 9);
    t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); t++; end
    chk(out_valid == 1, "bp_out_valid_rise", out_valid, 1);
    held = out_data;
    chk(held == q[0].v, "bp_out_data", $signed(held), q[0].v);
    repeat (20) begin
      @(negedge clk);
      chk(out_valid == 1 && out_data == held, "bp_hold", $signed(out_data), $signed(held));
      chk(in_ready == 0 && rails_zero && !k_ack_nxt, "bp_quiet", in_ready, 0);
    end
    bp = 0;
    push_range(10, 63);
    drain();
    chk(fd_cnt == 3, "frame_done_count3", fd_cnt, 3);

    rand_frame();
    build_model();
    push_range(0, 63);
    drain();
    chk(fd_cnt == 4, "frame_done_count4", fd_cnt, 4);

    hang = 1;
    rand_frame();
    build_model();
    push_range(0, 9);
    repeat (200) @(negedge clk);
    chk(err == 0, "err_before_timeout", err, 0);
    repeat (100) @(negedge clk);
    chk(err == 1, "err_after_timeout", err, 1);
    chk(out_valid == 0 && in_ready == 0 && !k_ack_nxt, "timeout_waiting", out_valid, 0);
    chk(k_x0_t == frame[0] && k_x3_t == frame[9], "timeout_rails_held", k_x0_t, frame[0] & 8'hFF);
    repeat (50) @(negedge clk);
    chk(err == 1, "err_sticky", err, 1);
    #3 reset_n = 0;
    #1;
    chk(rails_zero, "midrst_rails", 0, 1);
    chk(k_ack_nxt == 0 && out_valid == 0, "midrst_handshake", k_ack_nxt, 0);
    chk(err == 0 && in_ready == 0, "midrst_err", err, 0);
    @(negedge clk);
    q.delete();
    hang = 0;
    reset_n = 1;
    @(negedge clk);
    chk(in_ready == 1, "in_ready_after_midrst", in_ready, 1);

    rand_frame();
    build_model();
    push_range(0, 63);
    drain();
    chk(fd_cnt == 5, "frame_done_count5", fd_cnt, 5);
    chk(err == 0, "err_clear_after_rst", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
